// File: rtl/multi_delay_line_if.sv
// Stream bundle for the multi-channel delay line: shared beat strobe, packed per-channel
// samples and delays in, delayed samples and per-channel primed flags out.
interface multi_delay_line_if #(
    parameter int NCH       = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_DELAY = 16,
    parameter int DW        = $clog2(MAX_DELAY) + 1
);
    logic                 valid_in;
    logic [NCH*WIDTH-1:0] data_in;
    logic [NCH*DW-1:0]    delay;
    logic                 flush;
    logic                 valid_out;
    logic [NCH*WIDTH-1:0] data_out;
    logic [NCH-1:0]       primed;

    modport master (
        output valid_in, data_in, delay, flush,
        input  valid_out, data_out, primed
    );

    modport slave (
        input  valid_in, data_in, delay, flush,
        output valid_out, data_out, primed
    );
endinterface

// File: rtl/multi_delay_line.sv
// Purpose: NCH-channel delay line, per-channel delay counted in valid beats, lockstep channels.
// Latency: 1 cycle from accepted beat to registered output (plus the programmed beat delay).
// Backpressure: none; every beat accepted, every beat produces one output beat.
module multi_delay_line #(
    parameter int NCH       = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_DELAY = 16,
    parameter int DW        = $clog2(MAX_DELAY) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multi_delay_line_if.slave      io
);
    localparam int AW = $clog2(MAX_DELAY);
    localparam logic [DW-1:0] MAXD = DW'(MAX_DELAY);

    logic [AW-1:0]        wptr;
    logic [DW-1:0]        fill;
    logic                 valid_out_q;
    logic [NCH*WIDTH-1:0] data_out_q;
    logic [NCH-1:0]       primed_q;

    logic [NCH*WIDTH-1:0] nxt_dat;
    logic [NCH-1:0]       nxt_pr;
    logic                 beat;

    assign beat = io.valid_in && !io.flush;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [WIDTH-1:0] mem [MAX_DELAY];
        logic [DW-1:0]    d_raw;
        logic [DW-1:0]    d_cl;
        logic [AW-1:0]    rd_idx;
        logic             have_hist;

        assign d_raw = io.delay[c*DW +: DW];
        assign d_cl  = (d_raw > MAXD) ? MAXD : d_raw;
        // d==MAX_DELAY truncates to 0 here, selecting the slot about to be overwritten (oldest)
        assign rd_idx    = wptr - d_cl[AW-1:0];
        assign have_hist = (fill >= d_cl);

        assign nxt_pr[c] = (d_cl == '0) || have_hist;
        assign nxt_dat[c*WIDTH +: WIDTH] =
            (d_cl == '0) ? io.data_in[c*WIDTH +: WIDTH] :
            have_hist    ? mem[rd_idx] : '0;

        // Storage carries no reset: fill gates every read until slots are rewritten.
        always_ff @(posedge clk) begin
            if (beat) begin
                mem[wptr] <= io.data_in[c*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || io.flush) begin
            wptr        <= '0;
            fill        <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            primed_q    <= '0;
        end else begin
            valid_out_q <= io.valid_in;
            if (io.valid_in) begin
                wptr       <= wptr + AW'(1);
                fill       <= (fill == MAXD) ? fill : fill + DW'(1);
                data_out_q <= nxt_dat;
                primed_q   <= nxt_pr;
            end
        end
    end

    assign io.valid_out = valid_out_q;
    assign io.data_out  = data_out_q;
    assign io.primed    = primed_q;
endmodule

// File: tb/tb_multi_delay_line.sv
// Bench for multi_delay_line: directed scenarios with closed-form expectations plus a random
// phase, all compared against a history-queue reference model.
module tb_multi_delay_line;
    localparam int NCH   = 4;
    localparam int WIDTH = 32;
    localparam int MAXD  = 16;
    localparam int DW    = $clog2(MAXD) + 1;
    localparam int BW    = NCH * WIDTH;

    logic clk = 1'b0;
    logic rst_n;

    multi_delay_line_if #(.NCH(NCH), .WIDTH(WIDTH), .MAX_DELAY(MAXD)) io ();

    multi_delay_line #(.NCH(NCH), .WIDTH(WIDTH), .MAX_DELAY(MAXD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: every sample accepted since the last flush/reset, newest at the back.
    logic [BW-1:0]  hist [$];
    logic           exp_vo;
    logic [BW-1:0]  exp_do;
    logic [NCH-1:0] exp_pr;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*DW-1:0] pk(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_vo"}, BW'(io.valid_out), BW'(exp_vo));
        chk({tag, "_do"}, io.data_out, exp_do);
        chk({tag, "_pr"}, BW'(io.primed), BW'(exp_pr));
    endtask

    task automatic step(input logic v, input logic f, input logic [BW-1:0] din,
                        input logic [NCH*DW-1:0] dl, input string tag);
        int d;
        int n;
        io.valid_in = v;
        io.flush    = f;
        io.data_in  = din;
        io.delay    = dl;
        if (f) begin
            exp_vo = 1'b0;
            exp_do = '0;
            exp_pr = '0;
            hist.delete();
        end else begin
            exp_vo = v;
            if (v) begin
                n = hist.size();
                for (int k = 0; k < NCH; k++) begin
                    d = int'(dl[k*DW +: DW]);
                    if (d > MAXD) d = MAXD;
                    if (d == 0) begin
                        exp_do[k*WIDTH +: WIDTH] = din[k*WIDTH +: WIDTH];
                        exp_pr[k] = 1'b1;
                    end else if (n >= d) begin
                        exp_do[k*WIDTH +: WIDTH] = hist[n-d][k*WIDTH +: WIDTH];
                        exp_pr[k] = 1'b1;
                    end else begin
                        exp_do[k*WIDTH +: WIDTH] = '0;
                        exp_pr[k] = 1'b0;
                    end
                end
                hist.push_back(din);
                if (hist.size() > MAXD) void'(hist.pop_front());
            end
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    // Beat b (1-based since the last flush), same data b on every channel.
    task automatic beat_n(input int b, input int d0, input int d1, input int d2, input int d3,
                          input string tag);
        int dk [NCH];
        int e;
        dk = '{d0, d1, d2, d3};
        step(1'b1, 1'b0, {NCH{WIDTH'(b)}}, pk(d0, d1, d2, d3), tag);
        for (int k = 0; k < NCH; k++) begin
            e = (b > dk[k]) ? b - dk[k] : 0;
            chk({tag, "_cdat"}, BW'(io.data_out[k*WIDTH +: WIDTH]), BW'(e));
            chk({tag, "_cpr"}, BW'(io.primed[k]), BW'(b > dk[k]));
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n       = 1'b0;
        io.valid_in = 1'b1;
        io.flush    = 1'b0;
        io.data_in  = {NCH{32'hDEAD_BEEF}};
        exp_vo = 1'b0;
        exp_do = '0;
        exp_pr = '0;
        hist.delete();
        @(posedge clk);
        #1;
        check_model(tag);
        rst_n = 1'b1;
    endtask

    logic [NCH*DW-1:0] rdl;
    logic [31:0]       seq4 [4];

    initial begin
        rst_n       = 1'b0;
        io.valid_in = 1'b0;
        io.flush    = 1'b0;
        io.data_in  = '0;
        io.delay    = '0;
        exp_vo = 1'b0;
        exp_do = '0;
        exp_pr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst_n = 1'b1;

        // d=3 on every channel, data 1..8
        for (int b = 1; b <= 8; b++) beat_n(b, 3, 3, 3, 3, "t1");

        // d=0 bypass with idle gaps
        step(1'b1, 1'b1, '0, '0, "t2_flush");
        step(1'b1, 1'b0, {NCH{32'hA5}}, '0, "t2_a");
        chk("t2_a_const", BW'(io.data_out[31:0]), BW'(32'hA5));
        step(1'b0, 1'b0, {NCH{32'h77}}, '0, "t2_idle");
        chk("t2_hold", BW'(io.data_out[31:0]), BW'(32'hA5));
        chk("t2_idle_vo", BW'(io.valid_out), '0);
        step(1'b0, 1'b0, {NCH{32'h77}}, '0, "t2_idle2");
        step(1'b1, 1'b0, {NCH{32'h5A}}, '0, "t2_b");
        chk("t2_b_const", BW'(io.data_out[31:0]), BW'(32'h5A));

        // delays {0,1,2,16}, 40 beats, wptr wraps
        step(1'b0, 1'b1, '0, '0, "t3_flush");
        for (int b = 1; b <= 40; b++) beat_n(b, 0, 1, 2, 16, "t3");

        // flush coinciding with a beat
        step(1'b0, 1'b1, '0, '0, "t4_flush");
        for (int b = 1; b <= 5; b++) beat_n(b, 2, 2, 2, 2, "t4");
        step(1'b1, 1'b1, {NCH{32'd6}}, pk(2, 2, 2, 2), "t4_coinc");
        chk("t4_coinc_vo", BW'(io.valid_out), '0);
        seq4 = '{32'd0, 32'd0, 32'd11, 32'd12};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, {NCH{32'(11 + i)}}, pk(2, 2, 2, 2), "t4_re");
            chk("t4_re_const", BW'(io.data_out[31:0]), BW'(seq4[i]));
        end

        // delay decrease then increase within fill
        step(1'b0, 1'b1, '0, '0, "t5_flush");
        for (int b = 1; b <= 16; b++) begin
            if (b < 8)       beat_n(b, 4, 4, 4, 4, "t5");
            else if (b < 12) beat_n(b, 2, 2, 2, 2, "t5");
            else             beat_n(b, 6, 6, 6, 6, "t5");
        end

        // delay increase past fill, then reset mid-stream
        step(1'b0, 1'b1, '0, '0, "t6_flush");
        for (int b = 1; b <= 14; b++) begin
            if (b <= 9) beat_n(b, 8, 8, 8, 8, "t6");
            else        beat_n(b, 12, 12, 12, 12, "t6");
        end
        do_reset("t6_rst");

        // random beats, flushes, resets, delays 0..31 (clamping above 16)
        rdl = '0;
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < NCH; k++)
                if ($urandom_range(0, 7) == 0) rdl[k*DW +: DW] = DW'($urandom_range(0, 31));
            if ($urandom_range(0, 149) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
                     {$urandom, $urandom, $urandom, $urandom}, rdl, "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
